// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared encodings and helpers for the pipeline stall controller
// Purpose: Tuse/Tnew encodings, MDU latencies, sequencer state encoding,
//          and the per-source hazard test used by the top level.
// Ports:   none (package).
package pipe_stall_ctrl_pkg;

  // A source whose Tuse is 3 is not read by the instruction.
  localparam logic [1:0] TUSE_NONE  = 2'd3;
  // A producer whose Tnew is 0 already has its result ready for forwarding.
  localparam logic [1:0] TNEW_READY = 2'd0;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic [3:0] md_cycles(input logic op);
    return op ? DIV_CYCLES : MULT_CYCLES;
  endfunction

  // A source must wait when a younger-than-needed producer writes the same
  // non-zero register. The TUSE_NONE/TNEW_READY terms never change the result
  // of tuse < tnew; they are kept so the intent reads directly from the code.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse != TUSE_NONE) &&
           (tnew != TNEW_READY) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - requester/control bundle between pipeline and stall controller
// Purpose: groups the decode/execute/memory hazard inputs and the stall
//          controller outputs.
// Modports: master = pipeline side (drives hazard inputs, reads controls),
//           slave  = stall controller side.
interface pipe_stall_ctrl_if;

  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_write_number;
  logic [4:0]  M_write_number;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_op;

  logic        F_en;
  logic        D_en;
  logic        E_clr;
  logic        md_busy;
  logic        md_done;
  logic        md_err;
  logic [15:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
           E_write_number, M_write_number, E_tnew, M_tnew,
           E_md_start, E_md_op,
    input  F_en, D_en, E_clr, md_busy, md_done, md_err, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
           E_write_number, M_write_number, E_tnew, M_tnew,
           E_md_start, E_md_op,
    output F_en, D_en, E_clr, md_busy, md_done, md_err, stall_cnt
  );

endinterface

// File: rtl/mdu_busy_timer.sv
// rtl/mdu_busy_timer.sv - multiply/divide unit busy sequencer
// Purpose: tracks MDU occupancy after a start in E, emits a one-cycle done
//          pulse on completion and a sticky error on a start while busy.
// Ports: clk, reset (async, active-low), start (MDU start in E),
//        op (0 = mult, 1 = div), busy (level), done (pulse), err (sticky).
module mdu_busy_timer
  import pipe_stall_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic done,
  output logic err
);

  md_state_e  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       done_nxt;
  logic       err_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      err   <= err | err_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = md_cycles(op);
        end
      end
      MD_BUSY: begin
        // A start here is dropped; the running operation keeps its count.
        err_set = start;
        if (cnt == 4'd1) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline hazard detection and stall control
// Purpose: detects data hazards between D and E/M, MDU structural hazards,
//          drives the F/D enables and DE bubble, and counts stall cycles.
// Ports: clk, reset (async, active-low), bus (pipe_stall_ctrl_if.slave):
//        hazard inputs D_*/E_*/M_*, outputs F_en, D_en, E_clr, md_busy,
//        md_done, md_err, stall_cnt.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
);

  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic        md_busy;
  logic [15:0] stall_cnt;

  assign data_stall =
      src_hazard(bus.D_rs, bus.D_tuse_rs, bus.E_write_number, bus.E_tnew) |
      src_hazard(bus.D_rs, bus.D_tuse_rs, bus.M_write_number, bus.M_tnew) |
      src_hazard(bus.D_rt, bus.D_tuse_rt, bus.E_write_number, bus.E_tnew) |
      src_hazard(bus.D_rt, bus.D_tuse_rt, bus.M_write_number, bus.M_tnew);

  mdu_busy_timer u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (bus.E_md_start),
    .op    (bus.E_md_op),
    .busy  (md_busy),
    .done  (bus.md_done),
    .err   (bus.md_err)
  );

  // The start in E occupies the MDU from the next edge, so an MD instruction
  // in D must already hold off in the start cycle.
  assign md_stall = bus.D_is_md & (md_busy | bus.E_md_start);
  assign stall    = data_stall | md_stall;

  // Reset releases the pipeline regardless of the hazard inputs.
  assign bus.F_en    = ~(stall & reset);
  assign bus.D_en    = ~(stall & reset);
  assign bus.E_clr   = stall & reset;
  assign bus.md_busy = md_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Cycle index: cycle c is the interval after the c-th rising edge.
  int   cyc = 0;
  // Reference model: MDU occupancy as absolute cycle windows.
  int   m_bstart;
  int   m_bend;
  int   m_done;
  bit   m_err;
  int   m_scnt;

  pipe_stall_ctrl_if bus();

  pipe_stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy();
    return (cyc >= m_bstart) && (cyc <= m_bend);
  endfunction

  function automatic bit m_stall();
    bit ds;
    ds = 0;
    if (bus.D_rs != 0 && ((bus.D_rs == bus.E_write_number && bus.D_tuse_rs < bus.E_tnew) ||
                          (bus.D_rs == bus.M_write_number && bus.D_tuse_rs < bus.M_tnew)))
      ds = 1;
    if (bus.D_rt != 0 && ((bus.D_rt == bus.E_write_number && bus.D_tuse_rt < bus.E_tnew) ||
                          (bus.D_rt == bus.M_write_number && bus.D_tuse_rt < bus.M_tnew)))
      ds = 1;
    return ds | (bus.D_is_md & (m_busy() | bus.E_md_start));
  endfunction

  task automatic m_reset();
    m_bstart = -100;
    m_bend   = -100;
    m_done   = -100;
    m_err    = 0;
    m_scnt   = 0;
  endtask

  // Advance the model over the coming edge, then move to just after it.
  task automatic tick();
    bit st;
    bit b;
    int n;
    st = m_stall();
    b  = m_busy();
    if (bus.E_md_start) begin
      if (!b) begin
        n = bus.E_md_op ? 10 : 5;
        m_bstart = cyc + 1;
        m_bend   = cyc + n;
        m_done   = cyc + n + 1;
      end else begin
        m_err = 1;
      end
    end
    if (st && m_scnt < 65535) m_scnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    bus.D_rs = 0; bus.D_rt = 0; bus.D_tuse_rs = 3; bus.D_tuse_rt = 3; bus.D_is_md = 0;
    bus.E_write_number = 0; bus.M_write_number = 0; bus.E_tnew = 0; bus.M_tnew = 0;
    bus.E_md_start = 0; bus.E_md_op = 0;
  endtask

  task automatic drive_load_use();
    drive_idle();
    bus.D_rs = 5; bus.D_tuse_rs = 1; bus.E_write_number = 5; bus.E_tnew = 2;
  endtask

  task automatic test_reset();
    reset = 0;
    drive_load_use();
    bus.D_is_md = 1; bus.E_md_start = 1;
    m_reset();
    #3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.F_en !== 1'b1 || bus.D_en !== 1'b1 || bus.E_clr !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_en got F=%b D=%b clr=%b exp 1 1 0", bus.F_en, bus.D_en, bus.E_clr);
      end
      n_cmp++;
      if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0 || bus.md_err !== 1'b0 || bus.stall_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_state got busy=%b done=%b err=%b cnt=%0d exp 0 0 0 0",
                 bus.md_busy, bus.md_done, bus.md_err, bus.stall_cnt);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    drive_idle();
    reset = 1;
  endtask

  task automatic test_load_use();
    drive_load_use();
    #1;
    n_cmp++;
    if (bus.F_en !== 1'b0 || bus.D_en !== 1'b0 || bus.E_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL load_use_stall got F=%b D=%b clr=%b exp 0 0 1", bus.F_en, bus.D_en, bus.E_clr);
    end
    tick();
    // The bubble now sits in E; the producer has moved to M.
    bus.E_write_number = 0; bus.E_tnew = 0; bus.M_write_number = 5; bus.M_tnew = 1;
    #1;
    n_cmp++;
    if (bus.F_en !== 1'b1 || bus.E_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_release got F=%b clr=%b exp 1 0", bus.F_en, bus.E_clr);
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL load_use_cnt got %0d exp 1", bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_r0_exempt();
    drive_idle();
    bus.D_rs = 0; bus.E_write_number = 0; bus.D_tuse_rs = 0; bus.E_tnew = 2;
    #1;
    n_cmp++;
    if (bus.F_en !== 1'b1 || bus.D_en !== 1'b1 || bus.E_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_exempt got F=%b D=%b clr=%b exp 1 1 0", bus.F_en, bus.D_en, bus.E_clr);
    end
    tick();
    n_cmp++;
    if (bus.stall_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL r0_cnt got %0d exp 1", bus.stall_cnt);
    end
    drive_idle();
  endtask

  task automatic test_mult_timing();
    drive_idle();
    bus.E_md_start = 1; bus.E_md_op = 0;
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      n_cmp++;
      if (bus.md_busy !== (i <= 5) || bus.md_done !== (i == 6)) begin
        n_bad++;
        $display("FAIL mult_timing k+%0d got busy=%b done=%b exp %b %b",
                 i, bus.md_busy, bus.md_done, i <= 5, i == 6);
      end
      tick();
    end
  endtask

  task automatic test_div_md_stall();
    drive_idle();
    bus.D_is_md = 1; bus.E_md_start = 1; bus.E_md_op = 1;
    #1;
    n_cmp++;
    if (bus.F_en !== 1'b0 || bus.E_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL div_start_stall got F=%b clr=%b exp 0 1", bus.F_en, bus.E_clr);
    end
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 11; i++) begin
      #1;
      n_cmp++;
      if (bus.md_busy !== (i <= 10) || bus.F_en !== (i == 11) || bus.md_done !== (i == 11)) begin
        n_bad++;
        $display("FAIL div_stall k+%0d got busy=%b F=%b done=%b exp %b %b %b",
                 i, bus.md_busy, bus.F_en, bus.md_done, i <= 10, i == 11, i == 11);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_back_to_back_err();
    drive_idle();
    bus.E_md_start = 1; bus.E_md_op = 0;
    tick();                                   // cycle k+1
    bus.E_md_start = 0;
    tick();                                   // k+2
    tick();                                   // k+3
    bus.E_md_start = 1; bus.E_md_op = 1;      // start while busy: ignored
    #1;
    n_cmp++;
    if (bus.md_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_before got %b exp 0", bus.md_err);
    end
    tick();                                   // k+4
    bus.E_md_start = 0;
    #1;
    n_cmp++;
    if (bus.md_err !== 1'b1 || bus.md_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set got err=%b busy=%b exp 1 1", bus.md_err, bus.md_busy);
    end
    tick();                                   // k+5
    tick();                                   // k+6: done cycle, no reload happened
    #1;
    n_cmp++;
    if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b1) begin
      n_bad++;
      $display("FAIL no_reload got busy=%b done=%b exp 0 1", bus.md_busy, bus.md_done);
    end
    bus.E_md_start = 1; bus.E_md_op = 0;
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      n_cmp++;
      if (bus.md_busy !== (i <= 5) || bus.md_done !== (i == 6) || bus.md_err !== 1'b1) begin
        n_bad++;
        $display("FAIL back_to_back k+%0d got busy=%b done=%b err=%b exp %b %b 1",
                 i, bus.md_busy, bus.md_done, bus.md_err, i <= 5, i == 6);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit st;
    for (int i = 0; i < 400; i++) begin
      bus.D_rs = 5'($urandom_range(0, 3));
      bus.D_rt = 5'($urandom_range(0, 3));
      bus.D_tuse_rs = 2'($urandom_range(0, 3));
      bus.D_tuse_rt = 2'($urandom_range(0, 3));
      bus.D_is_md = ($urandom_range(0, 3) == 0);
      bus.E_write_number = 5'($urandom_range(0, 3));
      bus.M_write_number = 5'($urandom_range(0, 3));
      bus.E_tnew = 2'($urandom_range(0, 3));
      bus.M_tnew = 2'($urandom_range(0, 3));
      bus.E_md_start = ($urandom_range(0, 5) == 0);
      bus.E_md_op = 1'($urandom_range(0, 1));
      #1;
      st = m_stall();
      n_cmp++;
      if (bus.F_en !== !st || bus.D_en !== !st || bus.E_clr !== st) begin
        n_bad++;
        $display("FAIL rnd_ctrl cyc=%0d got F=%b D=%b clr=%b exp stall=%b", cyc, bus.F_en, bus.D_en, bus.E_clr, st);
      end
      n_cmp++;
      if (bus.md_busy !== m_busy() || bus.md_done !== (cyc == m_done) || bus.md_err !== m_err) begin
        n_bad++;
        $display("FAIL rnd_mdu cyc=%0d got busy=%b done=%b err=%b exp %b %b %b",
                 cyc, bus.md_busy, bus.md_done, bus.md_err, m_busy(), cyc == m_done, m_err);
      end
      n_cmp++;
      if (bus.stall_cnt !== 16'(m_scnt)) begin
        n_bad++;
        $display("FAIL rnd_cnt cyc=%0d got %0d exp %0d", cyc, bus.stall_cnt, m_scnt);
      end
      tick();
    end
    drive_idle();
    repeat (12) tick();
  endtask

  task automatic test_async_reset();
    drive_idle();
    bus.E_md_start = 1; bus.E_md_op = 1;
    tick();
    bus.E_md_start = 0;
    repeat (3) tick();
    #2;
    reset = 0;
    m_reset();
    drive_load_use();
    #1;
    n_cmp++;
    if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.md_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got busy=%b done=%b cnt=%0d err=%b exp 0 0 0 0",
               bus.md_busy, bus.md_done, bus.stall_cnt, bus.md_err);
    end
    n_cmp++;
    if (bus.F_en !== 1'b1 || bus.E_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_en got F=%b clr=%b exp 1 0", bus.F_en, bus.E_clr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    drive_idle();
    reset = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_cmp++;
      if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_done i=%0d got done=%b busy=%b exp 0 0", i, bus.md_done, bus.md_busy);
      end
    end
  endtask

  task automatic test_saturation();
    drive_idle();
    bus.D_rs = 5; bus.D_tuse_rs = 0; bus.E_write_number = 5; bus.E_tnew = 1;
    repeat (70000) tick();
    #1;
    n_cmp++;
    if (bus.stall_cnt !== 16'hFFFF || bus.stall_cnt !== 16'(m_scnt)) begin
      n_bad++;
      $display("FAIL saturate got %h exp ffff (model %0d)", bus.stall_cnt, m_scnt);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.stall_cnt !== 16'hFFFF || bus.F_en !== 1'b0) begin
      n_bad++;
      $display("FAIL no_wrap got cnt=%h F=%b exp ffff 0", bus.stall_cnt, bus.F_en);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_r0_exempt();
    test_mult_timing();
    test_div_md_stall();
    test_back_to_back_err();
    test_random();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
